// File: rtl/out1536_in128_dwidth_down.sv
// AXI-Stream width downsizer: one S_DWIDTH word in, S_DWIDTH/M_DWIDTH narrow beats out, LSB slice first.
// Optional macro DWC_DOWN_PREFETCH_EN adds a second holding register and a registered s_axis_tready.
module out1536_in128_dwidth_down #(
    parameter int S_DWIDTH = 1536,
    parameter int M_DWIDTH = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [S_DWIDTH-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [M_DWIDTH-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast
);
    localparam int RATIO = S_DWIDTH / M_DWIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               beat_cnt, beat_cnt_nxt;
    logic [RATIO-1:0][M_DWIDTH-1:0] buffer;
    logic                           s_hs, m_hs, last_beat, load_buf;

    assign last_beat     = (state == FULL) && (beat_cnt == LAST_BEAT);
    assign m_axis_tvalid = (state == FULL);
    assign m_axis_tlast  = last_beat;
    // Gate with valid so idle cycles show zeros rather than a stale slice.
    assign m_axis_tdata  = m_axis_tvalid ? buffer[beat_cnt] : '0;
    assign m_hs          = m_axis_tvalid & m_axis_tready;
    assign s_hs          = s_axis_tvalid & s_axis_tready;

`ifdef DWC_DOWN_PREFETCH_EN
    logic [S_DWIDTH-1:0] hold;
    logic                hold_full, hold_load, hold_take;

    // Only flops feed tready, so m_axis_tready never reaches the slave side.
    assign s_axis_tready = ~rst & ~hold_full;
`else
    assign s_axis_tready = ~rst & ((state == EMPTY) | (last_beat & m_axis_tready));
`endif

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        load_buf     = 1'b0;
`ifdef DWC_DOWN_PREFETCH_EN
        hold_load    = 1'b0;
        hold_take    = 1'b0;
`endif
        case (state)
            EMPTY: begin
                if (s_hs) begin
                    load_buf     = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = FULL;
                end
            end
            FULL: begin
                if (m_hs && !last_beat) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
`ifdef DWC_DOWN_PREFETCH_EN
                    hold_load    = s_hs;
`endif
                end else if (m_hs) begin
                    beat_cnt_nxt = '0;
`ifdef DWC_DOWN_PREFETCH_EN
                    // hold_full blocks s_hs, so at most one source is live here.
                    if (hold_full) hold_take = 1'b1;
                    else if (s_hs) load_buf  = 1'b1;
                    else           state_nxt = EMPTY;
`else
                    if (s_hs) load_buf  = 1'b1;
                    else      state_nxt = EMPTY;
`endif
                end else begin
`ifdef DWC_DOWN_PREFETCH_EN
                    hold_load = s_hs;
`endif
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            beat_cnt <= '0;
            buffer   <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (load_buf)
                buffer <= s_axis_tdata;
`ifdef DWC_DOWN_PREFETCH_EN
            else if (hold_take)
                buffer <= hold;
`endif
        end
    end

`ifdef DWC_DOWN_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (hold_load) begin
            hold      <= s_axis_tdata;
            hold_full <= 1'b1;
        end else if (hold_take) begin
            hold_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_out1536_in128_dwidth_down.sv
// Directed bench for out1536_in128_dwidth_down: single word, back-to-back, stalls,
// last-slice backpressure, mid-word reset, and the prefetch build when DWC_DOWN_PREFETCH_EN is set.
module tb_out1536_in128_dwidth_down;
    localparam int S_W = 1536;
    localparam int M_W = 128;
    localparam int RAT = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [S_W-1:0] s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [M_W-1:0] m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tlast;

    int total = 0;
    int bad   = 0;

    out1536_in128_dwidth_down dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Slice i of word <tag>: tag in the top byte, 0xA5 marker, slice index in the low byte.
    function automatic logic [M_W-1:0] sl(input logic [7:0] tag, input int i);
        return {tag, 104'h0, 8'hA5, 8'(i)};
    endfunction

    function automatic logic [S_W-1:0] wd(input logic [7:0] tag);
        logic [S_W-1:0] w;
        w = '0;
        for (int i = 0; i < RAT; i++) w[i*M_W +: M_W] = sl(tag, i);
        return w;
    endfunction

    // Expected {valid, last, data} of beat b of word tag.
    function automatic logic [M_W+1:0] bt(input logic [7:0] tag, input int b);
        return {1'b1, (b == RAT - 1), sl(tag, b)};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            bad++; $display("FAIL reset_out got=%h want=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata});
        end
        tick(); tick();
        rst = 1'b0; #1;
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_sready got=%b want=1", s_axis_tready); end
    endtask

    task automatic test_single();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h01);
        tick(); s_axis_tvalid = 1'b0; #1;
        for (int b = 0; b < RAT; b++) begin
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt(8'h01, b)) begin
                bad++; $display("FAIL single_beat%0d got=%h want=%h", b, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt(8'h01, b));
            end
            tick();
        end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", m_axis_tvalid); end
    endtask

    task automatic test_back_to_back();
        logic took;
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h02);
        tick(); s_axis_tdata = wd(8'h03); #1;
        for (int k = 0; k < 2 * RAT; k++) begin
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt((k < RAT) ? 8'h02 : 8'h03, k % RAT)) begin
                bad++; $display("FAIL b2b_beat%0d got=%h want=%h", k, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt((k < RAT) ? 8'h02 : 8'h03, k % RAT));
            end
`ifndef DWC_DOWN_PREFETCH_EN
            if (k == RAT - 1) begin
                total++;
                if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL b2b_sready_beat11 got=%b want=1", s_axis_tready); end
            end
`endif
            took = s_axis_tvalid & s_axis_tready;
            tick();
            if (took) s_axis_tvalid = 1'b0;
            #1;
        end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", m_axis_tvalid); end
    endtask

    task automatic test_stall();
        int exp_b = 0;
        int cyc = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h04); m_axis_tready = 1'b1;
        tick(); s_axis_tvalid = 1'b0;
        while (exp_b < RAT && cyc < 40) begin
            m_axis_tready = (cyc % 2 == 0); #1;
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt(8'h04, exp_b)) begin
                bad++; $display("FAIL stall_cyc%0d got=%h want=%h", cyc, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt(8'h04, exp_b));
            end
            if (m_axis_tready) exp_b++;
            tick(); cyc++;
        end
        total++;
        if (exp_b != RAT || m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL stall_end beats=%0d valid=%b want beats=12 valid=0", exp_b, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
    endtask

`ifndef DWC_DOWN_PREFETCH_EN
    task automatic test_last_backpressure();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h05);
        tick(); s_axis_tvalid = 1'b0;
        for (int b = 0; b < RAT - 1; b++) tick();
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h06);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b0, bt(8'h05, RAT - 1)}) begin
                bad++; $display("FAIL bp_hold%0d got=%h want=%h", c, {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b0, bt(8'h05, RAT - 1)});
            end
            tick();
        end
        m_axis_tready = 1'b1; #1;
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL bp_release_sready got=%b want=1", s_axis_tready); end
        tick(); s_axis_tvalid = 1'b0; #1;
        for (int b = 0; b < RAT; b++) begin
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt(8'h06, b)) begin
                bad++; $display("FAIL bp_word2_beat%0d got=%h want=%h", b, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt(8'h06, b));
            end
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h07);
        tick(); s_axis_tvalid = 1'b0;
        for (int b = 0; b < 5; b++) tick();
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt(8'h07, 5)) begin
            bad++; $display("FAIL rstmid_beat5 got=%h want=%h", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt(8'h07, 5));
        end
        #2 rst = 1'b1; #1;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            bad++; $display("FAIL rstmid_async got=%h want=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata});
        end
        tick(); rst = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h08);
        tick(); s_axis_tvalid = 1'b0; #1;
        for (int b = 0; b < RAT; b++) begin
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt(8'h08, b)) begin
                bad++; $display("FAIL rstmid_restart_beat%0d got=%h want=%h", b, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt(8'h08, b));
            end
            tick();
        end
    endtask

`ifdef DWC_DOWN_PREFETCH_EN
    task automatic test_prefetch();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = wd(8'h09);
        tick(); s_axis_tdata = wd(8'h0A); #1;
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL pf_sready_free got=%b want=1", s_axis_tready); end
        tick(); s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0; #1;
        total++;
        if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL pf_sready_mr0 got=%b want=0", s_axis_tready); end
        m_axis_tready = 1'b1; #1;
        total++;
        if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL pf_sready_mr1 got=%b want=0", s_axis_tready); end
        for (int k = 1; k < 2 * RAT; k++) begin
            total++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== bt((k < RAT) ? 8'h09 : 8'h0A, k % RAT)) begin
                bad++; $display("FAIL pf_beat%0d got=%h want=%h", k, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, bt((k < RAT) ? 8'h09 : 8'h0A, k % RAT));
            end
            tick();
        end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL pf_idle got=%b want=0", m_axis_tvalid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
`ifndef DWC_DOWN_PREFETCH_EN
        test_last_backpressure();
`else
        test_prefetch();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
